// File: rtl/spi_burst_ram.sv
// SPI slave-side single-port RAM with auto-incrementing writes and handshaked burst reads.
// Commands arrive as a 2-bit opcode plus payload word; bursts stream out under tx_valid/tx_ready.
module spi_burst_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  input  logic              drop_clr,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              busy,
  output logic              cmd_drop
);

  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [1:0] CmdSetWaddr = 2'b00;
  localparam logic [1:0] CmdWrite    = 2'b01;
  localparam logic [1:0] CmdSetRaddr = 2'b10;
  localparam logic [1:0] CmdBurst    = 2'b11;

  typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                tx_valid_q, tx_valid_d;
  logic                cmd_drop_q, cmd_drop_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [Depth];
  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic [DATA_W-1:0]   rd_data;

  assign cmd     = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];
  assign rd_data = mem[r_addr_q];
  assign busy    = (state_q != StIdle);

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[w_addr_q] <= payload;
    end
  end

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    tx_valid_d  = tx_valid_q;
    w_addr_d    = w_addr_q;
    r_addr_d    = r_addr_q;
    remaining_d = remaining_q;
    mem_we      = 1'b0;
    cmd_drop_d  = cmd_drop_q;

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_clr) begin
      cmd_drop_d = 1'b0;
    end
    if (rx_valid && busy) begin
      cmd_drop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          unique case (cmd)
            CmdSetWaddr: w_addr_d = payload[ADDR_W-1:0];
            CmdWrite: begin
              mem_we   = 1'b1;
              w_addr_d = w_addr_q + 1'b1;
            end
            CmdSetRaddr: r_addr_d = payload[ADDR_W-1:0];
            CmdBurst: begin
              remaining_d = payload[ADDR_W-1:0];
              state_d     = StFetch;
            end
            default: ;
          endcase
        end
      end
      StFetch: begin
        dout_d     = rd_data;
        tx_valid_d = 1'b1;
        r_addr_d   = r_addr_q + 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (remaining_q == '0) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            dout_d      = rd_data;
            r_addr_d    = r_addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dout_q      <= '0;
      tx_valid_q  <= 1'b0;
      cmd_drop_q  <= 1'b0;
      w_addr_q    <= '0;
      r_addr_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      tx_valid_q  <= tx_valid_d;
      cmd_drop_q  <= cmd_drop_d;
      w_addr_q    <= w_addr_d;
      r_addr_q    <= r_addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_drop = cmd_drop_q;

endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
- Parametrised successor to the SPI slave-side single-port RAM: same 2-bit command + payload word from the SPI receive path.
- Adds configurable data/address widths, auto-incrementing write address, and burst reads of N words.
- Burst reads stream out with a tx_valid/tx_ready handshake, so the SPI transmit path can backpressure.
- Commands arriving during a burst are dropped and flagged.

Parameters:
- DATA_W, 8, RAM word width in bits.
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W. Must satisfy ADDR_W <= DATA_W.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- din  in  DATA_W+2  din[DATA_W+1:DATA_W] = command, din[DATA_W-1:0] = payload
- rx_valid  in  1  din valid this cycle (single-cycle strobe per command)
- tx_ready  in  1  consumer accepts dout this cycle
- drop_clr  in  1  clears cmd_drop
- dout  out  DATA_W  read data
- tx_valid  out  1  dout valid
- busy  out  1  burst read in progress (state != IDLE)
- cmd_drop  out  1  sticky: a command arrived while busy

Behaviour:
- Reset (rst_n low at a clk edge):
  - dout=0, tx_valid=0, busy=0, cmd_drop=0, w_addr=0, r_addr=0, remaining=0, state=IDLE.
  - RAM contents are not reset.
- Commands, accepted only in IDLE with rx_valid=1:
  - 00 set write address: w_addr <= payload[ADDR_W-1:0]; upper payload bits ignored.
  - 01 write data: ram[w_addr] <= payload; w_addr <= w_addr+1, wrapping 2**ADDR_W-1 -> 0.
  - 10 set read address: r_addr <= payload[ADDR_W-1:0].
  - 11 burst read: remaining <= payload[ADDR_W-1:0], giving a burst length of payload+1 words (1..2**ADDR_W); state -> FETCH.
- FSM states: IDLE, FETCH, SEND.
  - IDLE -> FETCH on an accepted command 11; otherwise stays in IDLE.
  - FETCH (one cycle): dout <= ram[r_addr]; tx_valid <= 1; r_addr <= r_addr+1 (wrap); -> SEND.
  - SEND, tx_ready=0: dout and tx_valid held stable.
  - SEND, tx_ready=1 and remaining=0: tx_valid <= 0; -> IDLE.
  - SEND, tx_ready=1 and remaining>0: dout <= ram[r_addr]; r_addr++ (wrap); remaining--; tx_valid stays 1; state stays SEND.
- Latency and throughput:
  - First word is valid 2 cycles after the command-11 edge (FETCH edge, then visible).
  - Back-to-back words are delivered at 1 per cycle while tx_ready=1.
- After a burst, r_addr = start + burst length (mod depth); a following command 11 continues sequentially.
- busy is high in FETCH and SEND; it drops on the same edge tx_valid drops.
- rx_valid=1 while busy:
  - The command is ignored: no RAM, address or state change.
  - cmd_drop <= 1.
- cmd_drop:
  - drop_clr=1 clears it.
  - If drop_clr and a drop occur in the same cycle, set wins: cmd_drop=1.
- The cycle a burst finishes (SEND -> IDLE) counts as busy; a command arriving then is dropped.
- Read-during-write cannot occur: writes happen only in IDLE.
- Reset mid-burst: outputs return to reset values on that edge; no further words are emitted.
- dout holds the last read word after a burst ends (tx_valid=0); it is not cleared.

Test Plan:
- Reset, then write 00/0x10, 01/0xA1, 01/0xA2, 01/0xA3, then 10/0x10, 11/0x02 with tx_ready=1 -> dout A1,A2,A3 on 3 consecutive cycles with tx_valid=1; busy falls after A3; r_addr ends at 0x13.
- Same burst with tx_ready held 0 for 4 cycles after the first word -> dout stays A1 with tx_valid=1 throughout; no word is skipped or duplicated after tx_ready rises.
- Write-address wrap: 00/0xFF, 01/0x11, 01/0x22, then read 2 words from 0xFF -> 0x11, 0x22 (address 0x00 holds 0x22); burst read starting at 0xFF also wraps.
- Command 01/0x55 issued mid-burst -> ignored, cmd_drop=1 and stays 1; RAM unchanged on read-back. drop_clr pulse -> cmd_drop=0. Simultaneous drop and drop_clr -> cmd_drop=1.
- 11/0x00 -> exactly one word, tx_valid high for exactly 1 handshake. 11/0xFF (ADDR_W=8) -> 256 words, then idle.
- rst_n low for one cycle mid-burst -> next cycle tx_valid=0, busy=0, dout=0; a fresh 10/11 sequence works normally.
